// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: segment count,
// the legal segment widths and a legality check used at elaboration.
package pipe_add_pkg;

  localparam int BLOCK_4  = 4;
  localparam int BLOCK_8  = 8;
  localparam int BLOCK_16 = 16;

  function automatic int NSEG_F(input int width, input int block);
    return width / block;
  endfunction

  function automatic bit block_legal(input int block);
    return (block == BLOCK_4) || (block == BLOCK_8) || (block == BLOCK_16);
  endfunction

endpackage

// File: rtl/pipe_cla_adder_cla_segment.sv
// Combinational BLOCK-bit carry-lookahead adder built from 4-bit lookahead
// groups; exports the block generate/propagate for use by a wider lookahead.
module cla_segment #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             gg,
  output logic             pp
);

  localparam int NGRP = BLOCK / 4;

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_c;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      localparam int B0 = 4 * gi;
      assign grp_g[gi] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                       | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
      assign grp_p[gi] = &p[B0 +: 4];
      // Bit carries inside the group are fully expanded from the group carry-in
      assign c[B0]   = grp_c[gi];
      assign c[B0+1] = g[B0] | (p[B0] & grp_c[gi]);
      assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & grp_c[gi]);
      assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                     | ((&p[B0+2:B0]) & grp_c[gi]);
    end
  endgenerate

  always_comb begin
    grp_c    = '0;
    grp_c[0] = cin;
    for (int j = 0; j < NGRP - 1; j++) begin
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
    end
  end

  always_comb begin
    gg = 1'b0;
    pp = 1'b1;
    for (int j = 0; j < NGRP; j++) begin
      gg = grp_g[j] | (grp_p[j] & gg);
      pp = pp & grp_p[j];
    end
  end

  assign sum  = p ^ c;
  assign cout = gg | (pp & cin);

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one BLOCK-bit lookahead segment per
// stage, carry registered between stages, flags and saturation in the last.
module pipe_cla_adder
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG  = NSEG_F(WIDTH, BLOCK);
  localparam int NRANK = (NSEG > 1) ? NSEG - 1 : 1;

  generate
    if (!block_legal(BLOCK) || (WIDTH % BLOCK) != 0) begin : g_bad_param
      $fatal(1, "pipe_cla_adder: illegal WIDTH/BLOCK combination");
    end
  endgenerate

  // Operands are kept pre-shifted so each stage always consumes the low slice
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] sum_lo;
    logic             carry;
    logic             sat;
  } stage_t;

  stage_t stg_reg  [NRANK];
  stage_t stg_next [NRANK];

  logic             adv;
  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             fin_valid;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_cout;
  logic             fin_ovf;

  assign adv       = ~out_valid_reg | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_stage
      logic [WIDTH-1:0] op_a;
      logic [WIDTH-1:0] op_b;
      logic [WIDTH-1:0] part;
      logic [WIDTH-1:0] res;
      logic             c_in;
      logic             v_in;
      logic             sat_in;
      logic [BLOCK-1:0] seg_sum;
      logic             seg_cout;
      logic             seg_gg;
      logic             seg_pp;

      if (gi == 0) begin : g_src
        assign op_a   = a;
        assign op_b   = sub ? ~b : b;
        assign c_in   = sub | cin;
        assign part   = '0;
        assign v_in   = in_valid;
        assign sat_in = sat;
      end else begin : g_src
        assign op_a   = stg_reg[gi-1].a_hi;
        assign op_b   = stg_reg[gi-1].b_hi;
        assign c_in   = stg_reg[gi-1].carry;
        assign part   = stg_reg[gi-1].sum_lo;
        assign v_in   = stg_reg[gi-1].valid;
        assign sat_in = stg_reg[gi-1].sat;
      end

      cla_segment #(.BLOCK(BLOCK)) u_seg (
        .a    (op_a[BLOCK-1:0]),
        .b    (op_b[BLOCK-1:0]),
        .cin  (c_in),
        .sum  (seg_sum),
        .cout (seg_cout),
        .gg   (seg_gg),
        .pp   (seg_pp)
      );

      // New segment enters at the top; after NSEG stages the word is aligned
      assign res = WIDTH'({seg_sum, part} >> BLOCK);

      if (gi < NSEG - 1) begin : g_dst
        assign stg_next[gi] = '{valid:  v_in,
                                a_hi:   op_a >> BLOCK,
                                b_hi:   op_b >> BLOCK,
                                sum_lo: res,
                                carry:  seg_cout,
                                sat:    sat_in};
      end else begin : g_dst
        logic a_top;
        logic b_top;
        logic ovf_c;
        assign a_top     = op_a[BLOCK-1];
        assign b_top     = op_b[BLOCK-1];
        assign ovf_c     = (a_top == b_top) & (seg_sum[BLOCK-1] != a_top);
        assign fin_valid = v_in;
        assign fin_cout  = seg_cout;
        assign fin_ovf   = ovf_c;
        assign fin_sum   = (sat_in & ovf_c) ? (a_top ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {1'b0, {(WIDTH-1){1'b1}}})
                                            : res;
      end
    end

    if (NSEG == 1) begin : g_no_rank
      assign stg_next[0] = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NRANK; k++) begin
        stg_reg[k] <= '0;
      end
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NRANK; k++) begin
        stg_reg[k] <= stg_next[k];
      end
      out_valid_reg <= fin_valid;
      sum_reg       <= fin_sum;
      cout_reg      <= fin_cout;
      ovf_reg       <= fin_ovf;
    end
  end

endmodule
